telem_reader: RTL and testbench

TELEM_READER -- requirements
Module: telem_reader

---
 rtl/telem_pkg.sv | 20 ++
 rtl/telem_chksum.sv | 29 ++
 rtl/telem_reader.sv | 153 +++++++++++++++
 tb/tb_telem_reader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry frame reader.
// Widths, the default frame header and the frame FSM state encoding live here.
package telem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  localparam logic [DATA_W-1:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_FETCH,
    S_WAIT,
    S_DATA,
    S_CHK
  } state_e;

endpackage

// File: rtl/telem_chksum.sv
// Modulo-256 running sum of frame data bytes, with synchronous clear and add enable.
// Only instantiated when TELEM_CHKSUM_EN is defined.
module telem_chksum
  import telem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      // Carry out of bit 7 is intentionally dropped: the checksum is mod 256.
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/telem_reader.sv
// Reads NUM_ENTRIES telemetry registers and streams them as a valid/ready frame:
// HEADER, count, data bytes and, when TELEM_CHKSUM_EN is defined, a mod-256 checksum byte.
module telem_reader
  import telem_pkg::*;
#(
  parameter int                NUM_ENTRIES = 4,
  parameter logic [DATA_W-1:0] HEADER      = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] byte_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;

  logic              last_entry;
  logic [DATA_W-1:0] chk_byte;

  assign last_entry = (idx_q == LAST_IDX);

`ifdef TELEM_CHKSUM_EN
  logic [DATA_W-1:0] chk_sum;

  telem_chksum u_chksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == S_IDLE && start_i),
    .add_i  (state_q == S_DATA && tx_ready_i),
    .data_i (byte_q),
    .sum_o  (chk_sum)
  );

  // The final data byte is added in the same edge that loads the CHK byte,
  // so fold it in here rather than waiting a cycle for the accumulator.
  assign chk_byte = chk_sum + byte_q;
`else
  assign chk_byte = '0;
`endif

  // Every output is a register loaded alongside the state transition that
  // makes it true, so the sink and the bank see glitch-free, edge-aligned signals.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state, including the data byte register, is reset: a frame
    // aborted by reset must never leak a stale byte into the next frame.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      byte_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later lines in a branch
      // override these defaults without creating ordering hazards.
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          if (start_i) begin
            state_q    <= S_HDR;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_HDR: begin
          if (tx_ready_i) begin
            state_q   <= S_CNT;
            tx_data_q <= 8'(NUM_ENTRIES);
          end
        end
        S_CNT: begin
          if (tx_ready_i) begin
            state_q    <= S_FETCH;
            tx_valid_q <= 1'b0;
            rd_en_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          state_q    <= S_DATA;
          byte_q     <= rd_data_i;
          tx_data_q  <= rd_data_i;
          tx_valid_q <= 1'b1;
        end
        S_DATA: begin
          if (tx_ready_i) begin
            if (last_entry) begin
              idx_q <= '0;
`ifdef TELEM_CHKSUM_EN
              state_q   <= S_CHK;
              tx_data_q <= chk_byte;
`else
              state_q    <= S_IDLE;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              idx_q      <= idx_q + 1'b1;
              state_q    <= S_FETCH;
              tx_valid_q <= 1'b0;
              rd_en_q    <= 1'b1;
            end
          end
        end
        S_CHK: begin
          if (tx_ready_i) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = idx_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_telem_reader.sv
// Directed, table-driven bench for telem_reader (NUM_ENTRIES=4, HEADER=8'hA5).
// Honours TELEM_CHKSUM_EN to expect or omit the trailing checksum byte.
module tb_telem_reader;

  localparam int N = 4;
`ifdef TELEM_CHKSUM_EN
  localparam int NBYTES = N + 3;
  localparam int FRAME_CYC = 2 + 3 * N + 1;
`else
  localparam int NBYTES = N + 2;
  localparam int FRAME_CYC = 2 + 3 * N;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  logic [7:0] bank [0:31];
  logic [7:0] exp_bytes [0:NBYTES-1];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0][7:0] bank;
    logic [7:0]      chk;
    int              stall_at;
    int              stall_len;
  } vec_t;

  vec_t vecs [5];

  telem_reader #(.NUM_ENTRIES(N), .HEADER(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr),
    .rd_data_i  (rd_data),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Register bank: data appears the cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= bank[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, chk, input int sa, sl);
    vec_t r;
    r.bank      = {b3, b2, b1, b0};
    r.chk       = chk;
    r.stall_at  = sa;
    r.stall_len = sl;
    return r;
  endfunction

  // Runs one frame from vector v. hold keeps start high for the whole frame;
  // abort_at >= 0 asserts reset when that many bytes have gone and the next is offered.
  task automatic run_frame(input int v, input bit hold, input int abort_at);
    int nb = 0, bc = 0, fc = 0, st = 0;
    bit done_seen = 0;
    for (int i = 0; i < N; i++) bank[i] = vecs[v].bank[i];
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h04;
    for (int i = 0; i < N; i++) exp_bytes[2+i] = vecs[v].bank[i];
`ifdef TELEM_CHKSUM_EN
    exp_bytes[N+2] = vecs[v].chk;
`endif
    tx_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        done_seen = 1;
        check("done_not_busy", busy, 0);
        break;
      end
      if (busy) bc++;
      if (rd_en) begin
        check("rd_addr", rd_addr, fc);
        check("rd_en_no_valid", tx_valid, 0);
        fc++;
      end
      if (abort_at >= 0 && nb == abort_at && tx_valid) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        return;
      end
      if (tx_valid) begin
        if (nb == vecs[v].stall_at && st < vecs[v].stall_len) begin
          tx_ready = 1'b0;
          check("stall_hold", tx_data, exp_bytes[nb]);
          if (st == 0 && nb >= 2) bank[nb-2] = 8'hEE;
          st++;
        end else begin
          tx_ready = 1'b1;
          if (nb < NBYTES) check("byte", tx_data, exp_bytes[nb]);
          else check("extra_byte", nb, NBYTES - 1);
          nb++;
        end
      end else begin
        tx_ready = 1'b1;
      end
    end
    check("done_seen", done_seen, 1);
    check("nbytes", nb, NBYTES);
    check("busy_cycles", bc, FRAME_CYC + vecs[v].stall_len);
    check("fetches", fc, N);
    @(negedge clk);
    if (hold) begin
      check("restart_busy", busy, 1);
      check("restart_valid", tx_valid, 1);
      check("restart_hdr", tx_data, 8'hA5);
      check("restart_done_low", done, 0);
    end else begin
      check("done_one_pulse", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) bank[i] = 8'h00;

    vecs[0] = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, -1, 0);
    vecs[1] = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 3, 5);
    vecs[2] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, -1, 0);
    vecs[3] = mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, -1, 0);
    vecs[4] = mk(8'h80, 8'h80, 8'h00, 8'h7F, 8'h7F, 2, 2);

    #12;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_frame(v, 1'b0, -1);

    // start held through the frame: one frame only, then a new one from the done cycle.
    run_frame(0, 1'b1, -1);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Reset while offering the data byte of idx 2, then a clean frame.
    run_frame(2, 1'b0, 4);
    @(negedge clk); rst_n = 1'b1;
    run_frame(3, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
